// File: rtl/mul_div_pkg.sv
// Shared constants for the sequential multiply/divide controller and its external ALU.
package mul_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int ITER_COUNT = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/ALU_16Bit.sv
// Combinational 16-bit ALU (AND/OR/ADD/SLT) with A-invert and B-negate; BNegate doubles as carry-in.
module ALU_16Bit
  import mul_div_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [1:0]  ALUOp,
  input  logic        AInvert,
  input  logic        BNegate,
  output logic [15:0] Result,
  output logic        CarryOut
);

  logic [15:0] a_eff;
  logic [15:0] b_eff;
  logic [16:0] sum;
  logic        ovf;

  assign a_eff = AInvert ? ~A : A;
  assign b_eff = BNegate ? ~B : B;
  assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {16'd0, BNegate};
  assign ovf   = (a_eff[15] == b_eff[15]) && (sum[15] != a_eff[15]);
  assign CarryOut = sum[16];

  always_comb begin
    case (ALUOp)
      ALU_AND: Result = a_eff & b_eff;
      ALU_OR:  Result = a_eff | b_eff;
      ALU_ADD: Result = sum[15:0];
      default: Result = {15'd0, sum[15] ^ ovf};
    endcase
  end

endmodule

// File: rtl/mul_div_seq.sv
// Shift-add multiplier / restoring divider, one bit per cycle, borrowing an external ALU for the add/subtract.
// Start is taken only in IDLE; divide by zero skips straight to DONE.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo,
  output logic             DivByZero,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluOp,
  output logic             AluAInvert,
  output logic             AluBNegate,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut
);

  logic [1:0]       state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] sum;
  logic             c;

  // Divide shifts the next dividend bit into the partial remainder before subtracting.
  assign t = {p_q[WIDTH-2:0], q_q[WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    p_d        = p_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    sum        = p_q;
    c          = 1'b0;
    AluA       = '0;
    AluB       = '0;
    AluOp      = ALU_AND;
    AluAInvert = 1'b0;
    AluBNegate = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d  = Op;
          m_d   = OpB;
          q_d   = OpA;
          p_d   = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (Op == OP_DIV && OpB == '0) begin
            state_d = ST_DONE;
            hi_d    = OpA;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        AluB       = m_q;
        AluOp      = ALU_ADD;
        AluBNegate = op_q;
        if (op_q == OP_DIV) begin
          AluA = t;
          // R[15] set means T really holds 2^16 + t, which always exceeds D.
          if (p_q[WIDTH-1] | AluCarryOut) begin
            p_d = AluResult;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            p_d = t;
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          AluA = p_q;
          if (q_q[0]) begin
            c   = AluCarryOut;
            sum = AluResult;
          end
          p_d = {c, sum[WIDTH-1:1]};
          q_d = {sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) begin
          state_d = ST_DONE;
          hi_d    = p_d;
          lo_d    = q_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      p_q     <= p_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = (state_q == ST_ITER) || (state_q == ST_DONE);
  assign Done      = (state_q == ST_DONE);
  assign ResultHi  = hi_q;
  assign ResultLo  = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq wired to a real ALU_16Bit: vector table plus reset/ignored-Start sequences.
module tb_mul_div_seq;
  import mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        Op;
  logic [15:0] OpA, OpB;
  logic        Busy, Done, DivByZero;
  logic [15:0] ResultHi, ResultLo;
  logic [15:0] AluA, AluB, AluResult;
  logic [1:0]  AluOp;
  logic        AluAInvert, AluBNegate, AluCarryOut;

  int n_vec = 0;
  int n_mis = 0;
  logic cur_op = 1'b0;

  always #5 clk = ~clk;

  mul_div_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .ResultHi(ResultHi), .ResultLo(ResultLo),
    .DivByZero(DivByZero), .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
    .AluAInvert(AluAInvert), .AluBNegate(AluBNegate),
    .AluResult(AluResult), .AluCarryOut(AluCarryOut)
  );

  ALU_16Bit u_alu (
    .A(AluA), .B(AluB), .ALUOp(AluOp), .AInvert(AluAInvert), .BNegate(AluBNegate),
    .Result(AluResult), .CarryOut(AluCarryOut)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ALU control legality every cycle, and IDLE/DONE quiescence.
  always @(negedge clk) begin
    if (!rst) begin
      chk("alu_ainv_legal_op", {AluAInvert, AluOp[0]}, 64'd0);
      if (!Busy || Done)
        chk("alu_quiet", {AluA, AluB, AluOp, AluBNegate}, 64'd0);
      else
        chk("alu_iter_ctl", {AluOp, AluBNegate}, {62'd0, ALU_ADD, cur_op});
    end
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input string nm);
    int cyc, busy_n;
    bit seen;
    @(negedge clk);
    Start = 1'b1; Op = v.op; OpA = v.a; OpB = v.b;
    @(posedge clk);
    cur_op = v.op;
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        Start = 1'b0;
        chk({nm, "_dbz_first"}, {63'd0, DivByZero}, {63'd0, v.dbz});
      end
      if (Busy) busy_n++;
      if (Done) seen = 1;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(v.lat));
    chk({nm, "_result"}, {31'd0, v.dbz, v.hi, v.lo}, {31'd0, DivByZero, ResultHi, ResultLo});
    @(negedge clk);
    chk({nm, "_idle_after"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{OP_MUL, 16'd3,     16'd5,     16'h0000, 16'h000F, 1'b0, 17};
    vecs[1] = '{OP_MUL, 16'hFFFF,  16'hFFFF,  16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[2] = '{OP_DIV, 16'd100,   16'd7,     16'd2,    16'd14,   1'b0, 17};
    vecs[3] = '{OP_DIV, 16'hFFFF,  16'd1,     16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[4] = '{OP_DIV, 16'hFFFF,  16'h8000,  16'h7FFF, 16'h0001, 1'b0, 17};
    vecs[5] = '{OP_DIV, 16'd1234,  16'd0,     16'd1234, 16'hFFFF, 1'b1, 1};
    vecs[6] = '{OP_MUL, 16'h1234,  16'h0010,  16'h0001, 16'h2340, 1'b0, 17};
    vecs[7] = '{OP_DIV, 16'd7,     16'd100,   16'd7,    16'd0,    1'b0, 17};
    vecs[8] = '{OP_MUL, 16'h1234,  16'h0000,  16'h0000, 16'h0000, 1'b0, 17};
    vecs[9] = '{OP_DIV, 16'hABCD,  16'hABCD,  16'h0000, 16'h0001, 1'b0, 17};

    // Reset with a simultaneous Start: reset wins.
    rst = 1'b1; Start = 1'b1; Op = OP_MUL; OpA = 16'd3; OpB = 16'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {13'd0, Busy, Done, DivByZero, ResultHi, ResultLo}, 64'd0);
    chk("reset_alu", {AluA, AluB, AluOp, AluAInvert, AluBNegate}, 64'd0);
    Start = 1'b0; rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start held through ITER with different operands must be ignored.
    @(negedge clk);
    Start = 1'b1; Op = OP_MUL; OpA = 16'd3; OpB = 16'd5;
    @(posedge clk);
    cur_op = OP_MUL;
    begin
      int cyc;
      bit seen;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
        @(negedge clk);
        cyc++;
        Op = OP_DIV; OpA = 16'h5555; OpB = 16'd0;
        if (Done) seen = 1;
      end
      Start = 1'b0;
      chk("held_start_latency", 64'(cyc), 64'd17);
      chk("held_start_result", {32'd0, ResultHi, ResultLo}, 64'h0000_000F);
      chk("held_start_dbz", {63'd0, DivByZero}, 64'd0);
    end
    repeat (5) @(negedge clk);
    chk("result_held", {30'd0, Busy, Done, ResultHi, ResultLo}, 64'h0000_000F);

    // Reset in the middle of a divide.
    @(negedge clk);
    Start = 1'b1; Op = OP_DIV; OpA = 16'd100; OpB = 16'd7;
    @(posedge clk);
    cur_op = OP_DIV;
    @(negedge clk);
    Start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_iter_busy", {62'd0, Busy, Done}, 64'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_state", {13'd0, Busy, Done, DivByZero, ResultHi, ResultLo}, 64'd0);
    chk("abort_alu", {AluA, AluB, AluOp, AluAInvert, AluBNegate}, 64'd0);
    rst = 1'b0;
    begin
      int dn;
      dn = 0;
      repeat (20) begin
        @(negedge clk);
        if (Done || Busy) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'd0);
    end

    run_vec(vecs[2], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/ALU width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Op  input  1  0 = unsigned multiply, 1 = unsigned divide; captured with Start.
REQ-006 OpA  input  16  multiplicand or dividend; captured with Start.
REQ-007 OpB  input  16  multiplier or divisor; captured with Start.
REQ-008 Busy  output  1  high in states ITER and DONE.
REQ-009 Done  output  1  one-cycle completion pulse, high only in state DONE.
REQ-010 ResultHi  output  16  product[31:16] or remainder; held until the next accepted Start.
REQ-011 ResultLo  output  16  product[15:0] or quotient; held until the next accepted Start.
REQ-012 DivByZero  output  1  high with results of a divide whose OpB was 0; cleared on the next accepted Start.
REQ-013 AluA  output  16  operand A to the external ALU_16Bit.
REQ-014 AluB  output  16  operand B to the external ALU_16Bit.
REQ-015 AluOp  output  2  ALU operation select.
REQ-016 AluAInvert  output  1  ALU A-invert control.
REQ-017 AluBNegate  output  1  ALU B-negate control; also the ALU carry-in.
REQ-018 AluResult  input  16  combinational sum/difference returned from the ALU in the same cycle.
REQ-019 AluCarryOut  input  1  ALU carry out; for subtract, 1 = no borrow.

Function
REQ-020 States SHALL be IDLE, ITER and DONE.
- IDLE -> ITER on Start.
- IDLE -> DONE on Start with Op=1 and OpB=0.
- ITER -> DONE after exactly 16 ITER cycles.
- DONE -> IDLE unconditionally.
REQ-021 Start outside IDLE SHALL be ignored: no capture, no effect on the operation in progress.
REQ-022 On an accepted Start the block SHALL load: M/D = OpB; Q = OpA; P/R = 0; iteration counter = 0; DivByZero = 0.
REQ-023 The ALU SHALL be driven from registered state only, and AluResult/AluCarryOut sampled at the end of the same cycle.
REQ-024 In IDLE and DONE: AluA = 0, AluB = 0, AluOp = 00 (AND), AluAInvert = 0, AluBNegate = 0.
REQ-025 Multiply iteration: AluA = P, AluB = M, AluOp = 10 (ADD), AluBNegate = 0.
- If Q[0]=1: {C,P} = {AluCarryOut, AluResult}; otherwise {C,P} = {0,P}.
- Then {P,Q} is loaded with {C,P,Q} shifted right by one bit.
REQ-026 Divide iteration (restoring): T = {R[14:0],Q[15]}; AluA = T, AluB = D, AluOp = 10, AluBNegate = 1.
- If R[15] | AluCarryOut: R = AluResult and the quotient bit = 1.
- Otherwise: R = T and the quotient bit = 0.
- Q = {Q[14:0], quotient bit}.
REQ-027 Entering DONE: ResultHi = P/R; ResultLo = Q.
- Divide by zero instead gives ResultHi = OpA, ResultLo = 16'hFFFF, DivByZero = 1.
REQ-028 Latency, with Start sampled at edge k:
- Normal operation: Done is high in the cycle after edge k+16.
- Divide by zero: Done is high in the cycle after edge k.
REQ-029 AluAAInvert SHALL remain 0 in every state; AluOp values 01 (OR) and 11 (SLT) SHALL never be issued.
REQ-030 Arithmetic SHALL be unsigned, with no truncation: the product is the full 32 bits; the remainder is always less than the divisor.

Reset
REQ-031 While rst is high at a clock edge, the next state SHALL be IDLE.
REQ-032 At that same edge, Busy, Done, DivByZero, ResultHi, ResultLo, counter and all datapath registers SHALL be set to 0.
REQ-033 Reset during ITER or DONE SHALL abort the operation with no Done pulse; ALU outputs take their IDLE values from the next cycle.
REQ-034 Reset SHALL take priority over a simultaneous Start.

Structure
REQ-035 Package mul_div_pkg SHALL hold:
- the state enumeration;
- ALUOp constants ALU_AND=2'b00, ALU_OR=2'b01, ALU_ADD=2'b10, ALU_SLT=2'b11;
- ITER_COUNT=16;
- the Op encodings OP_MUL=0, OP_DIV=1.
REQ-036 mul_div_seq SHALL contain no sub-module; ALU_16Bit is instantiated beside it in the parent.

Verification
REQ-037 The bench SHALL connect mul_div_seq to a real ALU_16Bit and check the following scenarios.
- Mul 3 x 5 -> {ResultHi,ResultLo} = 0x0000_000F, Done in the 17th cycle after the Start edge, Busy high for 17 cycles.
- Mul 0xFFFF x 0xFFFF -> 0xFFFE_0001.
- Div 100 / 7 -> ResultLo = 14, ResultHi = 2, DivByZero = 0.
- Div 0xFFFF / 1 -> ResultLo = 0xFFFF, ResultHi = 0.
- Div 0xFFFF / 0x8000 -> ResultLo = 1, ResultHi = 0x7FFF.
- Div 1234 / 0 -> Done one cycle after the Start edge, DivByZero = 1, ResultHi = 1234, ResultLo = 0xFFFF.
- Start held during ITER -> ignored, and the first result is unchanged.
- rst at iteration 8 -> IDLE next cycle, all outputs 0, no Done.
- A fresh Start after the reset completes normally.
